ohc7_add_arbiter: RTL

Round-robin arbiter that shares one mod-7 one-hot-code (OHC) adder between NREQ requesters in the RNS datapath. Each requester presents two binary residues (0..6). The granted pair is converted to 7-bit OHC and added by one-hot rotation. The result is returned through a single-entry output register with a valid/ready handshake, tagged with the requester ID. It sits between the RNS operand sources and the mod-7 residue channel consumers.

---
 rtl/rns_ohc7_pkg.sv | 32 +++
 rtl/ohc7_mod_add.sv | 34 +++
 rtl/ohc7_add_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rns_ohc7_pkg.sv
// Shared constants, types and helpers for the mod-7 one-hot residue channel.
package rns_ohc7_pkg;

  localparam int MOD7   = 7;
  localparam int OHC7_W = 7;
  localparam int RES_W  = 3;

  typedef logic [OHC7_W-1:0] ohc7_t;
  typedef logic [RES_W-1:0]  res3_t;

  // Residue 0 in one-hot form, and the all-zero code flagging an illegal operand.
  localparam ohc7_t OHC7_ZERO = 7'b0000001;
  localparam ohc7_t OHC7_ERR  = 7'b0000000;

  // Binary residue to one-hot. An input of 7 shifts out and yields all zeros.
  function automatic ohc7_t to_ohc7(input res3_t x);
    logic [7:0] wide;
    wide = 8'b0000_0001 << x;
    return wide[6:0];
  endfunction

  // Rotate a 7-bit one-hot code left by 0..6 positions. The code is doubled
  // so bits shifted past the top wrap back into the low end of the upper half.
  function automatic ohc7_t rotl7(input ohc7_t code, input res3_t amt);
    logic [13:0] dbl;
    logic [13:0] sh;
    dbl = {code, code};
    sh  = dbl << amt;
    return sh[13:7];
  endfunction

endpackage

// File: rtl/ohc7_mod_add.sv
// Combinational mod-7 adder: converts two binary residues to one-hot, adds
// them by rotation and also produces the matching binary sum.
module ohc7_mod_add
  import rns_ohc7_pkg::*;
(
  input  res3_t a,
  input  res3_t b,
  output ohc7_t sum_ohc,
  output res3_t sum_bin,
  output logic  err
);

  ohc7_t      ohc_a;
  ohc7_t      ohc_rot;
  logic [3:0] sum4;
  logic [3:0] sum4_wrap;

  // Operand conversion, one-hot rotation and 4-bit binary reduction.
  always_comb begin
    ohc_a     = to_ohc7(a);
    ohc_rot   = rotl7(ohc_a, b);
    sum4      = {1'b0, a} + {1'b0, b};
    sum4_wrap = sum4 - 4'(MOD7);
    err       = (a == 3'd7) || (b == 3'd7);
    if (err) begin
      sum_ohc = OHC7_ERR;
      sum_bin = '0;
    end else begin
      sum_ohc = ohc_rot;
      sum_bin = (sum4 >= 4'(MOD7)) ? sum4_wrap[2:0] : sum4[2:0];
    end
  end

endmodule

// File: rtl/ohc7_add_arbiter.sv
// Round-robin arbiter sharing one mod-7 one-hot adder among NREQ requesters.
// The sum lands in a single-entry output register with valid/ready handshake
// and is tagged with the owning requester's index.
module ohc7_add_arbiter
  import rns_ohc7_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_a,
  input  logic [3*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [6:0]        res_ohc,
  output logic [2:0]        res_bin,
  output logic              res_err
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic            state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q;
  ohc7_t           ohc_q;
  res3_t           bin_q;
  logic            err_q;

  logic            grant_any;
  logic [IDW-1:0]  grant_idx;
  logic [NREQ-1:0] grant_vec;
  logic            can_accept;
  logic            xfer;
  int              scan_idx;

  res3_t           op_a, op_b;
  ohc7_t           add_ohc;
  res3_t           add_bin;
  logic            add_err;

  // Register empty, or being drained this cycle, so a new result fits.
  // When empty, res_ready plays no part.
  assign can_accept = (state_q == ST_EMPTY) | res_ready;

  // Scan from the requester after the last winner, wrapping, and take the
  // first valid one.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = (int'(ptr_q) + k) % NREQ;
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(scan_idx);
      end
    end
  end

  // One-hot grant decode, gated by room in the output register and reset.
  always_comb begin
    grant_vec = '0;
    if (grant_any) begin
      grant_vec[grant_idx] = 1'b1;
    end
    req_ready = (rst_n && can_accept) ? grant_vec : '0;
  end

  assign xfer = rst_n & grant_any & can_accept;

  // Route the granted requester's residues to the shared adder.
  always_comb begin
    op_a = req_a[3*int'(grant_idx) +: 3];
    op_b = req_b[3*int'(grant_idx) +: 3];
  end

  ohc7_mod_add u_add (
    .a       (op_a),
    .b       (op_b),
    .sum_ohc (add_ohc),
    .sum_bin (add_bin),
    .err     (add_err)
  );

  // Output register occupancy; a simultaneous drain and transfer keeps it full.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL:  if (res_ready && !xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // The pointer moves to the winner only when a request actually transfers.
  assign ptr_d = xfer ? grant_idx : ptr_q;

  // State, pointer and result registers; reset discards any held result and
  // points at NREQ-1 so requester 0 is first in line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= IDW'(NREQ - 1);
      id_q    <= '0;
      ohc_q   <= OHC7_ZERO;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (xfer) begin
        id_q  <= grant_idx;
        ohc_q <= add_ohc;
        bin_q <= add_bin;
        err_q <= add_err;
      end
    end
  end

  assign res_valid = (state_q == ST_FULL);
  assign res_id    = id_q;
  assign res_ohc   = ohc_q;
  assign res_bin   = bin_q;
  assign res_err   = err_q;

endmodule
